// File: rtl/demux_1a2_32bits_buf.sv
// -----------------------------------------------------------------------------
// demux_1a2_32bits_buf
//
// Buffered 1-to-2 demultiplexer. A single valid/ready input stream is steered
// word by word into one of two output channels by the Control bit. Each
// channel owns a small FIFO, so back-pressure on one consumer never stalls
// traffic addressed to the other.
//
// Parameters
//   WIDTH  data width of Entrada / Salida_0 / Salida_1
//   DEPTH  entries per channel FIFO (power of 2, >= 2)
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high; empties both FIFOs
//   Control    in   1      destination of the current word (0 -> ch0, 1 -> ch1)
//   Entrada    in   WIDTH  input data
//   Valido_in  in   1      Entrada/Control are valid
//   Listo_in   out  1      the channel addressed by Control has room
//   Salida_0   out  WIDTH  ch0 head word (0 when ch0 is empty)
//   Valido_0   out  1      ch0 holds at least one word
//   Listo_0    in   1      ch0 consumer accepts the head word
//   Salida_1   out  WIDTH  ch1 head word (0 when ch1 is empty)
//   Valido_1   out  1      ch1 holds at least one word
//   Listo_1    in   1      ch1 consumer accepts the head word
//   Conteo_0   out  16     ch0 delivered-word count, saturating
//   Conteo_1   out  16     ch1 delivered-word count, saturating
//
// Build option
//   DEMUX_CONTEO_EN  when defined, the Conteo_0/Conteo_1 ports and their
//                    saturating counters are present; otherwise they are absent.
// -----------------------------------------------------------------------------
module demux_1a2_32bits_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Control,
    input  logic [WIDTH-1:0] Entrada,
    input  logic             Valido_in,
    output logic             Listo_in,
    output logic [WIDTH-1:0] Salida_0,
    output logic             Valido_0,
    input  logic             Listo_0,
    output logic [WIDTH-1:0] Salida_1,
    output logic             Valido_1,
    input  logic             Listo_1
`ifdef DEMUX_CONTEO_EN
    ,
    output logic [15:0]      Conteo_0,
    output logic [15:0]      Conteo_1
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

`ifdef DEMUX_CONTEO_EN
    // Delivered-word counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction
`endif

    // Per-channel status and handshakes, bit k belongs to channel k.
    logic [1:0]       full_v;
    logic [1:0]       empty_v;
    logic [1:0]       sel_v;
    logic [1:0]       push_v;
    logic [1:0]       pop_v;
    logic [WIDTH-1:0] head_v [2];
`ifdef DEMUX_CONTEO_EN
    logic [15:0]      conteo_v [2];
`endif

    // Listo_in depends only on Control and registered occupancy; the
    // consumer-side Listo_k never reaches it, so a pop cannot free a slot
    // for a push in the same cycle.
    assign sel_v    = {Control, ~Control};
    assign Listo_in = Control ? ~full_v[1] : ~full_v[0];
    assign push_v   = {2{Valido_in}} & sel_v & ~full_v;
    // No output handshake completes while reset is asserted.
    assign pop_v    = {Listo_1, Listo_0} & ~empty_v & {2{~reset}};

    genvar ch;
    for (ch = 0; ch < 2; ch++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    wr_ptr_q;
        logic [AW-1:0]    rd_ptr_q;
        logic [AW:0]      count_q;

        assign full_v[ch]  = (count_q == CNT_FULL);
        assign empty_v[ch] = (count_q == '0);
        assign head_v[ch]  = mem[rd_ptr_q];

        // Storage carries no reset: an empty channel masks its head to 0.
        always_ff @(posedge clk) begin
            if (push_v[ch]) begin
                mem[wr_ptr_q] <= Entrada;
            end
        end

        // Occupancy and pointers; pointers wrap modulo DEPTH.
        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_v[ch]) begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                end
                if (pop_v[ch]) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
                unique case ({push_v[ch], pop_v[ch]})
                    2'b10:   count_q <= count_q + CNT_ONE;
                    2'b01:   count_q <= count_q - CNT_ONE;
                    default: count_q <= count_q;
                endcase
            end
        end

`ifdef DEMUX_CONTEO_EN
        logic [15:0] conteo_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                conteo_q <= '0;
            end else if (pop_v[ch]) begin
                conteo_q <= sat_inc(conteo_q);
            end
        end

        assign conteo_v[ch] = conteo_q;
`endif
    end

    assign Valido_0 = ~empty_v[0];
    assign Valido_1 = ~empty_v[1];
    assign Salida_0 = empty_v[0] ? '0 : head_v[0];
    assign Salida_1 = empty_v[1] ? '0 : head_v[1];

`ifdef DEMUX_CONTEO_EN
    assign Conteo_0 = conteo_v[0];
    assign Conteo_1 = conteo_v[1];
`endif

endmodule

// File: tb/tb_demux_1a2_32bits_buf.sv
// -----------------------------------------------------------------------------
// tb_demux_1a2_32bits_buf
//
// Directed and randomized stimulus for demux_1a2_32bits_buf. A queue-per-channel
// model predicts every output each cycle; a handful of directed steps also
// check literal values.
// -----------------------------------------------------------------------------
module tb_demux_1a2_32bits_buf;

    localparam int W = 32;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         Control;
    logic [W-1:0] Entrada;
    logic         Valido_in;
    logic         Listo_in;
    logic [W-1:0] Salida_0;
    logic         Valido_0;
    logic         Listo_0;
    logic [W-1:0] Salida_1;
    logic         Valido_1;
    logic         Listo_1;
`ifdef DEMUX_CONTEO_EN
    logic [15:0]  Conteo_0;
    logic [15:0]  Conteo_1;
`endif

    demux_1a2_32bits_buf #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .Control   (Control),
        .Entrada   (Entrada),
        .Valido_in (Valido_in),
        .Listo_in  (Listo_in),
        .Salida_0  (Salida_0),
        .Valido_0  (Valido_0),
        .Listo_0   (Listo_0),
        .Salida_1  (Salida_1),
        .Valido_1  (Valido_1),
        .Listo_1   (Listo_1)
`ifdef DEMUX_CONTEO_EN
        ,
        .Conteo_0  (Conteo_0),
        .Conteo_1  (Conteo_1)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: one FIFO queue per channel plus delivered counts.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    int           cnt0 = 0;
    int           cnt1 = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0] e_s0, e_s1;
        logic         e_li;
        e_s0 = (q0.size() > 0) ? q0[0] : '0;
        e_s1 = (q1.size() > 0) ? q1[0] : '0;
        e_li = Control ? (q1.size() < D) : (q0.size() < D);
        chk("valido_0", W'(Valido_0), W'(q0.size() > 0));
        chk("salida_0", Salida_0, e_s0);
        chk("valido_1", W'(Valido_1), W'(q1.size() > 0));
        chk("salida_1", Salida_1, e_s1);
        chk("listo_in", W'(Listo_in), W'(e_li));
`ifdef DEMUX_CONTEO_EN
        chk("conteo_0", W'(Conteo_0), W'(cnt0));
        chk("conteo_1", W'(Conteo_1), W'(cnt1));
`endif
    endtask

    // Applies the handshake rules to the inputs seen on the current edge.
    task automatic model_update();
        bit p0, p1, o0, o1;
        p0 = Valido_in && !Control && (q0.size() < D);
        p1 = Valido_in &&  Control && (q1.size() < D);
        o0 = Listo_0 && (q0.size() > 0);
        o1 = Listo_1 && (q1.size() > 0);
        if (o0) begin
            void'(q0.pop_front());
            if (cnt0 < 65535) cnt0++;
        end
        if (o1) begin
            void'(q1.pop_front());
            if (cnt1 < 65535) cnt1++;
        end
        if (p0) q0.push_back(Entrada);
        if (p1) q1.push_back(Entrada);
    endtask

    task automatic step(input logic ctl, input logic [W-1:0] d, input logic vin,
                        input logic l0, input logic l1);
        @(negedge clk);
        Control   = ctl;
        Entrada   = d;
        Valido_in = vin;
        Listo_0   = l0;
        Listo_1   = l1;
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset     = 1'b1;
        Valido_in = 1'b0;
        Listo_0   = 1'b1;
        Listo_1   = 1'b1;
        Control   = 1'b0;
        repeat (n) @(posedge clk);
        q0.delete();
        q1.delete();
        cnt0 = 0;
        cnt1 = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valido_0", W'(Valido_0), '0);
        chk("rst_valido_1", W'(Valido_1), '0);
        chk("rst_salida_0", Salida_0, '0);
        chk("rst_salida_1", Salida_1, '0);
        chk("rst_listo_in", W'(Listo_in), W'(1));
`ifdef DEMUX_CONTEO_EN
        chk("rst_conteo_0", W'(Conteo_0), '0);
        chk("rst_conteo_1", W'(Conteo_1), '0);
`endif
    endtask

    initial begin
        reset     = 1'b1;
        Control   = 1'b0;
        Entrada   = '0;
        Valido_in = 1'b0;
        Listo_0   = 1'b0;
        Listo_1   = 1'b0;

        // Power-on reset held for two cycles.
        do_reset(2);

        // Routing: each word lands on its own channel one cycle after its push.
        step(1'b0, 32'hAAAA0001, 1'b1, 1'b1, 1'b1);
        #1;
        chk("route_v0", W'(Valido_0), W'(1));
        chk("route_s0", Salida_0, 32'hAAAA0001);
        chk("route_v1_idle", W'(Valido_1), '0);
        step(1'b1, 32'hBBBB0002, 1'b1, 1'b1, 1'b1);
        #1;
        chk("route_v1", W'(Valido_1), W'(1));
        chk("route_s1", Salida_1, 32'hBBBB0002);
        chk("route_v0_drained", W'(Valido_0), '0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);

        // Back-pressure on ch0: two words fit, the third is refused,
        // while ch1 still accepts.
        step(1'b0, 32'd1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'd2, 1'b1, 1'b0, 1'b1);
        #1;
        chk("full_listo_in", W'(Listo_in), '0);
        step(1'b0, 32'd3, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'hC1, 1'b1, 1'b0, 1'b1);
        #1;
        chk("other_ch_v1", W'(Valido_1), W'(1));
        chk("other_ch_s1", Salida_1, 32'hC1);

        // Full ch0 with a simultaneous pop: the pop happens, the push waits.
        step(1'b0, 32'd3, 1'b1, 1'b1, 1'b1);
        #1;
        chk("fullpop_head2", Salida_0, 32'd2);
        step(1'b0, 32'd3, 1'b1, 1'b1, 1'b1);
        #1;
        chk("fullpop_head3", Salida_0, 32'd3);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        #1;
        chk("fullpop_empty", W'(Valido_0), '0);

        // Mid-operation reset with words buffered on both channels.
        step(1'b0, 32'h11, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h12, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h21, 1'b1, 1'b0, 1'b0);
        do_reset(1);
        repeat (3) step(1'b0, '0, 1'b0, 1'b1, 1'b1);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom,
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) != 0));
        end
        repeat (4) step(1'b0, '0, 1'b0, 1'b1, 1'b1);

`ifdef DEMUX_CONTEO_EN
        // Delivered-word counters: exact count, then saturation.
        do_reset(1);
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b1, 1'b0, 1'b1);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("conteo_1_five", W'(Conteo_1), W'(5));
        chk("conteo_0_zero", W'(Conteo_0), '0);
        while (cnt1 < 65534) step(1'b1, $urandom, 1'b1, 1'b0, 1'b1);
        #1;
        chk("conteo_1_fffe", W'(Conteo_1), W'(16'hFFFE));
        repeat (3) step(1'b1, $urandom, 1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("conteo_1_sat", W'(Conteo_1), W'(16'hFFFF));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
